// File: rtl/acl2_spi_responder_if.sv
// Pin bundle of the ACL2-style SPI responder: SPI pins, measurement feed,
// event inputs and the interrupt/soft-reset outputs.
interface acl2_spi_responder_if;
    logic        ei_sck;
    logic        ei_csn;
    logic        ei_copi;
    logic        eo_cipo_o;
    logic        eo_cipo_t;
    logic        eo_int1;
    logic        eo_int2;
    logic [63:0] i_meas_data;
    logic        i_meas_load;
    logic        i_evt_act;
    logic        i_evt_inact;
    logic        o_soft_reset;

    modport master (
        output ei_sck, ei_csn, ei_copi, i_meas_data, i_meas_load, i_evt_act, i_evt_inact,
        input  eo_cipo_o, eo_cipo_t, eo_int1, eo_int2, o_soft_reset
    );
    modport slave (
        input  ei_sck, ei_csn, ei_copi, i_meas_data, i_meas_load, i_evt_act, i_evt_inact,
        output eo_cipo_o, eo_cipo_t, eo_int1, eo_int2, o_soft_reset
    );
endinterface

// File: rtl/acl2_spi_responder.sv
// SPI mode-0 register responder emulating an accelerometer: oversampled SPI,
// register file, coherent measurement snapshot, status and interrupt pins.
module acl2_spi_responder #(
    parameter int         parm_sync_stages = 2,
    parameter logic [7:0] parm_part_id     = 8'hF2
) (
    input logic                  i_clk_20mhz,
    input logic                  i_rst_20mhz,
    acl2_spi_responder_if.slave  bus
);
    typedef enum logic [2:0] {ST_IDLE, ST_INSTR, ST_ADDR, ST_WRITE, ST_READ, ST_IGNORE} state_t;
    state_t r_state, w_next;

    logic [2:0] r_sync [parm_sync_stages];   // {sck, csn, copi}
    logic       r_sck_q, r_csn_q;
    logic       w_sck, w_csn, w_copi;
    logic       w_sck_rise, w_sck_fall, w_csn_rise, w_csn_fall, w_active, w_byte_done;
    logic [6:0] r_rx;
    logic [7:0] w_rx_next;
    logic [2:0] r_bitcnt;
    logic       r_rw;
    logic [5:0] r_addr;
    logic [7:0] r_tx;
    logic       r_tx_load;
    logic [7:0] r_status, w_status;
    logic [7:0] r_meas [8];
    logic [7:0] r_wr [15];
    logic       r_pend;
    logic [63:0] r_pend_data, w_meas_src;
    logic       w_apply, w_soft_now;
    logic       r_soft, r_int1, r_int2;
    logic [7:0] w_rd_data;

    assign w_sck      = r_sync[parm_sync_stages-1][2];
    assign w_csn      = r_sync[parm_sync_stages-1][1];
    assign w_copi     = r_sync[parm_sync_stages-1][0];
    assign w_sck_rise = w_sck & ~r_sck_q;
    assign w_sck_fall = ~w_sck & r_sck_q;
    assign w_csn_rise = w_csn & ~r_csn_q;
    assign w_csn_fall = ~w_csn & r_csn_q;
    assign w_active   = ~w_csn && (r_state != ST_IDLE);
    assign w_rx_next  = {r_rx, w_copi};
    assign w_byte_done = w_active && w_sck_rise && (r_bitcnt == 3'd7);
    assign w_soft_now = w_byte_done && (r_state == ST_WRITE) && (r_addr == 6'h1F) && (w_rx_next == 8'h52);

    // A load while the bus is idle lands immediately; a held load lands on csn rise.
    assign w_apply    = w_csn && (bus.i_meas_load || (w_csn_rise && r_pend));
    assign w_meas_src = bus.i_meas_load ? bus.i_meas_data : r_pend_data;

    always_ff @(posedge i_clk_20mhz or posedge i_rst_20mhz) begin
        if (i_rst_20mhz) begin
            for (int i = 0; i < parm_sync_stages; i++) r_sync[i] <= 3'b010;
            r_sck_q <= 1'b0;
            r_csn_q <= 1'b1;
        end else begin
            r_sync[0] <= {bus.ei_sck, bus.ei_csn, bus.ei_copi};
            for (int i = 1; i < parm_sync_stages; i++) r_sync[i] <= r_sync[i-1];
            r_sck_q <= w_sck;
            r_csn_q <= w_csn;
        end
    end

    always_ff @(posedge i_clk_20mhz or posedge i_rst_20mhz) begin
        if (i_rst_20mhz) r_state <= ST_IDLE;
        else             r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (w_csn_rise) begin
            w_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:  if (w_csn_fall) w_next = ST_INSTR;
                ST_INSTR: if (w_byte_done)
                              w_next = (w_rx_next == 8'h0A || w_rx_next == 8'h0B) ? ST_ADDR : ST_IGNORE;
                ST_ADDR:  if (w_byte_done) w_next = r_rw ? ST_WRITE : ST_READ;
                default:  w_next = r_state;
            endcase
        end
    end

    always_comb begin
        w_rd_data = 8'h00;
        case (r_addr)
            6'h00: w_rd_data = 8'hAD;
            6'h01: w_rd_data = 8'h1D;
            6'h02: w_rd_data = parm_part_id;
            6'h03: w_rd_data = 8'h01;
            6'h0B: w_rd_data = r_status;
            default: begin
                if (r_addr inside {[6'h0E:6'h15]})      w_rd_data = r_meas[r_addr[2:0] + 3'd2];
                else if (r_addr inside {[6'h20:6'h2E]}) w_rd_data = r_wr[r_addr[3:0]];
            end
        endcase
    end

    always_comb begin
        w_status = r_status;
        if (w_soft_now) w_status = 8'h00;
        if (w_byte_done && r_state == ST_READ && (r_addr inside {[6'h0E:6'h15]})) w_status[0] = 1'b0;
        if (w_byte_done && r_state == ST_READ && r_addr == 6'h0B) w_status[5:4] = 2'b00;
        if (w_apply)         w_status[0] = 1'b1;
        if (bus.i_evt_act)   w_status[4] = 1'b1;
        if (bus.i_evt_inact) w_status[5] = 1'b1;
    end

    always_ff @(posedge i_clk_20mhz or posedge i_rst_20mhz) begin
        if (i_rst_20mhz) begin
            r_rx        <= '0;
            r_bitcnt    <= '0;
            r_rw        <= 1'b0;
            r_addr      <= '0;
            r_tx        <= '0;
            r_tx_load   <= 1'b0;
            r_status    <= '0;
            r_pend      <= 1'b0;
            r_pend_data <= '0;
            r_soft      <= 1'b0;
            r_int1      <= 1'b0;
            r_int2      <= 1'b0;
            for (int k = 0; k < 8; k++)  r_meas[k] <= '0;
            for (int k = 0; k < 15; k++) r_wr[k]   <= '0;
        end else begin
            r_soft <= w_soft_now;
            if (w_csn_fall) r_bitcnt <= '0;
            else if (w_active && w_sck_rise) begin
                r_rx     <= w_rx_next[6:0];
                r_bitcnt <= r_bitcnt + 3'd1;
            end

            if (w_byte_done) begin
                case (r_state)
                    ST_INSTR: r_rw <= (w_rx_next == 8'h0A);
                    ST_ADDR: begin
                        r_addr    <= w_rx_next[5:0];
                        r_tx      <= '0;
                        r_tx_load <= 1'b1;
                    end
                    ST_WRITE: begin
                        if (r_addr inside {[6'h20:6'h2E]}) r_wr[r_addr[3:0]] <= w_rx_next;
                        else if (w_soft_now) for (int k = 0; k < 15; k++) r_wr[k] <= '0;
                        r_addr <= r_addr + 6'd1;
                    end
                    ST_READ: begin
                        r_addr    <= r_addr + 6'd1;
                        r_tx_load <= 1'b1;
                    end
                    default: ;
                endcase
            end else if (r_state == ST_READ && w_active && w_sck_fall) begin
                // First falling edge of a byte presents the register; later ones shift.
                if (r_tx_load) begin
                    r_tx      <= w_rd_data;
                    r_tx_load <= 1'b0;
                end else begin
                    r_tx <= {r_tx[6:0], 1'b0};
                end
            end

            if (w_apply) begin
                for (int k = 0; k < 8; k++) r_meas[k] <= w_meas_src[63-8*k -: 8];
                r_pend <= 1'b0;
            end else if (bus.i_meas_load) begin
                r_pend      <= 1'b1;
                r_pend_data <= bus.i_meas_data;
            end

            r_status <= w_status;
            r_int1   <= (|(r_status[6:0] & r_wr[10][6:0])) ^ r_wr[10][7];
            r_int2   <= (|(r_status[6:0] & r_wr[11][6:0])) ^ r_wr[11][7];
        end
    end

    assign bus.eo_cipo_t    = w_csn;
    assign bus.eo_cipo_o    = (r_state == ST_READ) ? r_tx[7] : 1'b0;
    assign bus.eo_int1      = r_int1;
    assign bus.eo_int2      = r_int2;
    assign bus.o_soft_reset = r_soft;
endmodule

// File: tb/tb_acl2_spi_responder.sv
// Directed bench for acl2_spi_responder: SPI mode-0 controller model with a
// queue of expected read bytes popped as each byte comes back on cipo.
module tb_acl2_spi_responder;
    localparam int HALF = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #25 clk = ~clk;

    acl2_spi_responder_if bus();

    acl2_spi_responder #(.parm_sync_stages(2), .parm_part_id(8'hF2)) dut (
        .i_clk_20mhz (clk),
        .i_rst_20mhz (rst),
        .bus         (bus)
    );

    int checks = 0;
    int errors = 0;
    int soft_cnt = 0;
    logic [7:0] exp_q [$];
    logic [7:0] rx;

    always @(negedge clk) if (bus.o_soft_reset === 1'b1) soft_cnt++;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic xfer(input logic [7:0] tx, input int n, output logic [7:0] r);
        r = '0;
        for (int i = 0; i < n; i++) begin
            bus.ei_copi = tx[7-i];
            repeat (HALF) @(negedge clk);
            r = {r[6:0], bus.eo_cipo_o};
            bus.ei_sck = 1'b1;
            repeat (HALF) @(negedge clk);
            bus.ei_sck = 1'b0;
        end
    endtask

    task automatic cs_low();
        bus.ei_csn = 1'b0;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic cs_high();
        repeat (HALF) @(negedge clk);
        bus.ei_csn = 1'b1;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        logic [7:0] r;
        cs_low();
        xfer(8'h0A, 8, r);
        xfer(a, 8, r);
        xfer(d, 8, r);
        cs_high();
    endtask

    task automatic pop_chk(input string tag, input logic [7:0] obs);
        if (exp_q.size() == 0) begin
            chk({tag, "_empty_queue"}, obs, 64'hDEAD);
        end else begin
            chk(tag, obs, exp_q.pop_front());
        end
    endtask

    task automatic rd(input logic [7:0] a, input int n, input string tag);
        logic [7:0] r;
        cs_low();
        chk({tag, "_cipo_t"}, bus.eo_cipo_t, 1'b0);
        xfer(8'h0B, 8, r);
        xfer(a, 8, r);
        for (int i = 0; i < n; i++) begin
            xfer(8'h00, 8, r);
            pop_chk(tag, r);
        end
        cs_high();
    endtask

    task automatic load(input logic [63:0] d);
        @(negedge clk);
        bus.i_meas_data = d;
        bus.i_meas_load = 1'b1;
        @(negedge clk);
        bus.i_meas_load = 1'b0;
    endtask

    initial begin
        bus.ei_sck = 1'b0; bus.ei_csn = 1'b1; bus.ei_copi = 1'b0;
        bus.i_meas_data = '0; bus.i_meas_load = 1'b0;
        bus.i_evt_act = 1'b0; bus.i_evt_inact = 1'b0;
        repeat (4) @(negedge clk);
        chk("rst_cipo_t", bus.eo_cipo_t, 1'b1);
        chk("rst_cipo_o", bus.eo_cipo_o, 1'b0);
        chk("rst_int1", bus.eo_int1, 1'b0);
        chk("rst_int2", bus.eo_int2, 1'b0);
        chk("rst_soft", bus.o_soft_reset, 1'b0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // Fixed ID registers
        exp_q.push_back(8'hAD); exp_q.push_back(8'h1D);
        exp_q.push_back(8'hF2); exp_q.push_back(8'h01);
        rd(8'h00, 4, "id");

        // Measurement load, DATA_READY interrupt, burst read clears it
        wr(8'h2A, 8'h01);
        load(64'h1122334455667788);
        repeat (4) @(negedge clk);
        chk("int1_set", bus.eo_int1, 1'b1);
        for (int k = 1; k <= 8; k++) exp_q.push_back(8'(k * 8'h11));
        rd(8'h0E, 8, "meas");
        chk("int1_clr", bus.eo_int1, 1'b0);

        // Load during a burst stays pending until csn rises
        cs_low();
        xfer(8'h0B, 8, rx);
        xfer(8'h0E, 8, rx);
        xfer(8'h00, 8, rx);
        chk("coh_b0", rx, 8'h11);
        load(64'hA1A2A3A4A5A6A7A8);
        for (int k = 2; k <= 8; k++) exp_q.push_back(8'(k * 8'h11));
        for (int k = 0; k < 7; k++) begin
            xfer(8'h00, 8, rx);
            pop_chk("coh_old", rx);
        end
        cs_high();
        chk("coh_int1", bus.eo_int1, 1'b1);
        for (int k = 1; k <= 8; k++) exp_q.push_back(8'(8'hA0 + k));
        rd(8'h0E, 8, "coh_new");

        // Writes to 0x3F and wrapped 0x00 are ignored; read wraps
        cs_low();
        xfer(8'h0A, 8, rx); xfer(8'h3F, 8, rx);
        xfer(8'h55, 8, rx); xfer(8'h66, 8, rx);
        cs_high();
        exp_q.push_back(8'h00); exp_q.push_back(8'hAD);
        rd(8'h3F, 2, "wrap");

        // Soft reset
        soft_cnt = 0;
        wr(8'h1F, 8'h52);
        chk("soft_pulse", soft_cnt, 1);
        exp_q.push_back(8'h00);
        rd(8'h2A, 1, "soft_2a");
        exp_q.push_back(8'h00);
        rd(8'h1F, 1, "rd_1f");

        // Unsupported instruction: cipo quiet, nothing changes
        cs_low();
        xfer(8'h0D, 8, rx);
        xfer(8'h00, 8, rx);
        chk("fifo_b0", rx, 8'h00);
        xfer(8'h00, 8, rx);
        chk("fifo_b1", rx, 8'h00);
        cs_high();
        exp_q.push_back(8'hAD);
        rd(8'h00, 1, "after_fifo");

        // ACT event routed to INT2, cleared by reading STATUS
        wr(8'h2B, 8'h10);
        @(negedge clk); bus.i_evt_act = 1'b1;
        @(negedge clk); bus.i_evt_act = 1'b0;
        repeat (4) @(negedge clk);
        chk("int2_set", bus.eo_int2, 1'b1);
        exp_q.push_back(8'h10);
        rd(8'h0B, 1, "status");
        chk("int2_clr", bus.eo_int2, 1'b0);

        // Reset in the middle of an address byte
        cs_low();
        xfer(8'h0B, 8, rx);
        xfer(8'h00, 3, rx);
        #10 rst = 1'b1;
        #5;
        chk("mid_cipo_t", bus.eo_cipo_t, 1'b1);
        chk("mid_cipo_o", bus.eo_cipo_o, 1'b0);
        chk("mid_int2", bus.eo_int2, 1'b0);
        bus.ei_csn = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (HALF) @(negedge clk);
        exp_q.push_back(8'hAD);
        rd(8'h00, 1, "post_rst");
        exp_q.push_back(8'h00);
        rd(8'h2B, 1, "post_rst_2b");
        exp_q.push_back(8'h00);
        rd(8'h0E, 1, "post_rst_meas");
        chk("queue_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/acl2_spi_responder.md
ACL2_SPI_RESPONDER -- requirements
Module: acl2_spi_responder

Interface
REQ-001 SHALL provide parameter parm_sync_stages, default 2, input synchronizer depth for ei_sck/ei_csn/ei_copi.
REQ-002 SHALL provide parameter parm_part_id, default 8'hF2, value returned at address 0x02; 0x00=8'hAD, 0x01=8'h1D, 0x03=8'h01 fixed.
REQ-003 SHALL have ports: i_clk_20mhz  in  1  sole clock; i_rst_20mhz  in  1  reset, asynchronous, active-high.
REQ-004 SHALL have ports: ei_sck  in  1  SPI clock, mode 0; ei_csn  in  1  chip select, active-low; ei_copi  in  1  controller-out data.
REQ-005 SHALL have ports: eo_cipo_o  out  1  peripheral-out data; eo_cipo_t  out  1  tristate, 1=high-Z.
REQ-006 SHALL have ports: eo_int1, eo_int2  out  1 each  interrupt pins.
REQ-007 SHALL have ports: i_meas_data  in  64  XL,XH,YL,YH,ZL,ZH,TL,TH with [63:56] to 0x0E ... [7:0] to 0x15; i_meas_load  in  1  load strobe.
REQ-008 SHALL have ports: i_evt_act, i_evt_inact  in  1 each  event pulses; o_soft_reset  out  1  one-cycle pulse.

Function
REQ-009 SHALL synchronize ei_sck/ei_csn/ei_copi through parm_sync_stages flops and detect sck edges from synchronized samples; correct operation guaranteed for sck period >= 8 clocks.
REQ-010 SHALL run FSM states ST_IDLE, ST_INSTR, ST_ADDR, ST_WRITE, ST_READ, ST_IGNORE; synchronized csn rising from any state -> ST_IDLE next cycle.
REQ-011 SHALL move ST_IDLE -> ST_INSTR on synchronized csn falling; bit counter cleared.
REQ-012 SHALL sample copi MSB-first on each detected sck rising edge; byte complete at 8th edge.
REQ-013 SHALL on instruction byte: 0x0A -> ST_ADDR(write), 0x0B -> ST_ADDR(read), any other (incl. 0x0D FIFO) -> ST_IGNORE.
REQ-014 SHALL on address byte latch 6-bit address (bits [5:0]), go ST_WRITE or ST_READ.
REQ-015 SHALL in ST_WRITE write each completed byte to current address if 0x1F..0x2E, ignore otherwise; then address+1.
REQ-016 SHALL in ST_READ load tx shift with reg[address] on first sck falling edge after byte boundary, shift left on subsequent falling edges; eo_cipo_o = shift MSB; address+1 per byte.
REQ-017 SHALL wrap address 0x3F -> 0x00; addresses 0x04..0x0A, 0x16..0x1E, 0x2F..0x3F read 8'h00.
REQ-018 SHALL drive eo_cipo_t=0 while synchronized csn low, else 1; eo_cipo_o=0 outside ST_READ.
REQ-019 SHALL discard partial bytes at csn rising; no write, no address increment.
REQ-020 SHALL copy i_meas_data to 0x0E..0x15 on i_meas_load when csn high; when csn low, hold load pending and apply on csn rising (burst coherency); newer load overwrites pending.
REQ-021 SHALL maintain STATUS 0x0B: bit0 DATA_READY set on applied load; bit4 ACT set on i_evt_act; bit5 INACT set on i_evt_inact; other bits 0.
REQ-022 SHALL clear DATA_READY on completed read byte of any 0x0E..0x15; clear ACT/INACT on completed read byte of 0x0B; set wins over clear in same cycle.
REQ-023 SHALL compute eo_int1 = (|(STATUS[6:0] & reg0x2A[6:0])) XOR reg0x2A[7]; eo_int2 same with reg0x2B; registered.
REQ-024 SHALL on write byte 0x52 to 0x1F clear 0x20..0x2E and STATUS, pulse o_soft_reset one cycle; 0x1F reads 8'h00.

Reset
REQ-025 SHALL on i_rst_20mhz async assert: FSM ST_IDLE, all writable regs/STATUS/measurement regs 0, pending load cleared, eo_cipo_t=1, eo_cipo_o=0, eo_int1/eo_int2=0, o_soft_reset=0; mid-transaction reset aborts it.

Verification
REQ-026 Read 0x0B,0x00 + 4 dummy bytes -> cipo returns AD,1D,F2,01.
REQ-027 Write 0x0A,0x2A,0x01 then i_meas_load data 0x1122334455667788 -> eo_int1=1; burst read from 0x0E returns 11..88; eo_int1=0 after last measurement byte.
REQ-028 i_meas_load mid-burst read -> burst returns old values; new values read after csn rise.
REQ-029 Write 0x0A,0x3F,0x55,0x66 -> both ignored; read 0x0B,0x3F,2 bytes returns 00,AD (wrap).
REQ-030 Write 0x0A,0x1F,0x52 -> o_soft_reset pulse, 0x2A reads 00; instruction 0x0D -> cipo 0, no state change.
REQ-031 Assert reset after 3 bits of address byte -> outputs at reset values; next transaction decodes normally.
